tx_symbol_mapper: RTL and testbench

TX_SYMBOL_MAPPER -- requirements
Module: tx_symbol_mapper

---
 rtl/tx_symbol_mapper.sv | 214 +++++++++++++++++++++
 tb/tb_tx_symbol_mapper.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/tx_symbol_mapper.sv
// Gray-coded 4-ASK transmit mapper: input symbol FIFO plus IDLE/PREAMBLE/DATA framing.
// Define TX_PREAMBLE_EN to build the alternating +/-3b preamble generator in front of each frame.
module tx_symbol_mapper #(
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned PREAMBLE_LEN = 16,
   parameter int unsigned FRAME_LEN    = 1024
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clk_en,
   input  logic               frame_start,
   input  logic               sym_valid,
   input  logic [1:0]         sym_in,
   output logic               sym_ready,
   output logic signed [17:0] mapper_out,
   output logic               out_valid,
   output logic               frame_active,
   output logic               underflow
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned FRM_W = 16;
   localparam int unsigned PRE_W = 8;

   localparam logic signed [17:0] C_POS3 = 18'sd49152;
   localparam logic signed [17:0] C_POS1 = 18'sd16384;
   localparam logic signed [17:0] C_NEG1 = -18'sd16384;
   localparam logic signed [17:0] C_NEG3 = -18'sd49152;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_PREAMBLE = 2'd1,
      S_DATA     = 2'd2
   } state_t;

   if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of 2 and at least 2");
   end
   if ((PREAMBLE_LEN < 1) || (PREAMBLE_LEN > 255)) begin : g_bad_pre
      $error("PREAMBLE_LEN must be in 1..255");
   end
   if ((FRAME_LEN < 1) || (FRAME_LEN > 65535)) begin : g_bad_frame
      $error("FRAME_LEN must be in 1..65535");
   end

   state_t                r_state;
   state_t                w_state_nxt;
   state_t                w_slot;
   logic                  r_start_pend;
   logic                  w_start_nxt;
   logic [1:0]            r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [CNT_W-1:0]      r_count;
   logic [CNT_W-1:0]      w_count_nxt;
   logic                  r_sym_ready;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_empty;
   logic [FRM_W-1:0]      r_data_cnt;
   logic [FRM_W-1:0]      w_data_cnt_nxt;
`ifdef TX_PREAMBLE_EN
   logic [PRE_W-1:0]      r_pre_cnt;
   logic [PRE_W-1:0]      w_pre_cnt_nxt;
`endif
   logic signed [17:0]    r_out;
   logic signed [17:0]    w_out_nxt;
   logic                  r_out_valid;
   logic                  r_underflow;
   logic                  w_under_nxt;
   logic                  r_frame_active;

   function automatic logic signed [17:0] map_sym(input logic [1:0] s);
      case (s)
         2'b00:   map_sym = C_NEG3;
         2'b01:   map_sym = C_NEG1;
         2'b11:   map_sym = C_POS1;
         default: map_sym = C_POS3;
      endcase
   endfunction

   assign w_push  = sym_valid && r_sym_ready;
   assign w_empty = (r_count == '0);

   // Framing FSM: a pending start turns the IDLE strobe into the first slot of the frame
   always_comb begin
      w_state_nxt    = r_state;
      w_slot         = r_state;
      w_start_nxt    = r_start_pend;
      w_pop          = 1'b0;
      w_out_nxt      = r_out;
      w_under_nxt    = 1'b0;
      w_data_cnt_nxt = r_data_cnt;
`ifdef TX_PREAMBLE_EN
      w_pre_cnt_nxt  = r_pre_cnt;
`endif
      if ((r_state == S_IDLE) && frame_start) begin
         w_start_nxt = 1'b1;
      end
      if (clk_en) begin
         w_out_nxt = '0;
         if ((r_state == S_IDLE) && r_start_pend) begin
            w_start_nxt = 1'b0;
`ifdef TX_PREAMBLE_EN
            w_slot      = S_PREAMBLE;
`else
            w_slot      = S_DATA;
`endif
         end
         case (w_slot)
`ifdef TX_PREAMBLE_EN
            S_PREAMBLE: begin
               w_out_nxt = r_pre_cnt[0] ? C_NEG3 : C_POS3;
               if (r_pre_cnt == PRE_W'(PREAMBLE_LEN - 1)) begin
                  w_state_nxt   = S_DATA;
                  w_pre_cnt_nxt = '0;
               end else begin
                  w_state_nxt   = S_PREAMBLE;
                  w_pre_cnt_nxt = r_pre_cnt + PRE_W'(1);
               end
            end
`endif
            S_DATA: begin
               if (!w_empty) begin
                  w_pop     = 1'b1;
                  w_out_nxt = map_sym(r_mem[r_rd_ptr]);
               end else begin
                  w_under_nxt = 1'b1;
               end
               if (r_data_cnt == FRM_W'(FRAME_LEN - 1)) begin
                  w_state_nxt    = S_IDLE;
                  w_data_cnt_nxt = '0;
               end else begin
                  w_state_nxt    = S_DATA;
                  w_data_cnt_nxt = r_data_cnt + FRM_W'(1);
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      w_count_nxt = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + CNT_W'(1);
         2'b01:   w_count_nxt = r_count - CNT_W'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= S_IDLE;
         r_start_pend   <= 1'b0;
         r_data_cnt     <= '0;
         r_out          <= '0;
         r_out_valid    <= 1'b0;
         r_underflow    <= 1'b0;
         r_frame_active <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_start_pend   <= w_start_nxt;
         r_data_cnt     <= w_data_cnt_nxt;
         r_out          <= w_out_nxt;
         r_out_valid    <= clk_en;
         r_underflow    <= w_under_nxt;
         r_frame_active <= (w_state_nxt != S_IDLE);
      end
   end

`ifdef TX_PREAMBLE_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pre_cnt <= '0;
      end else begin
         r_pre_cnt <= w_pre_cnt_nxt;
      end
   end
`endif

   // Symbol FIFO; reset drops buffered symbols by clearing pointers and occupancy
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_sym_ready <= 1'b1;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         r_count     <= w_count_nxt;
         r_sym_ready <= (w_count_nxt != CNT_W'(FIFO_DEPTH));
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= sym_in;
      end
   end

   assign sym_ready    = r_sym_ready;
   assign mapper_out   = r_out;
   assign out_valid    = r_out_valid;
   assign frame_active = r_frame_active;
   assign underflow    = r_underflow;

endmodule

// File: tb/tb_tx_symbol_mapper.sv
// Directed bench for tx_symbol_mapper: instance A (depth 4, frame 6) and instance B (depth 8, frame 3).
// Expected preamble samples are included only when TX_PREAMBLE_EN is defined.
module tb_tx_symbol_mapper;

`ifdef TX_PREAMBLE_EN
   localparam int unsigned NP = 2;
`else
   localparam int unsigned NP = 0;
`endif
   localparam logic signed [17:0] P3 = 18'sd49152;
   localparam logic signed [17:0] P1 = 18'sd16384;
   localparam logic signed [17:0] N1 = -18'sd16384;
   localparam logic signed [17:0] N3 = -18'sd49152;
   localparam logic signed [17:0] Z0 = 18'sd0;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic               a_en, a_fs, a_sv, a_rdy, a_ov, a_act, a_und;
   logic [1:0]         a_si;
   logic signed [17:0] a_out;
   logic               b_en, b_fs, b_sv, b_rdy, b_ov, b_act, b_und;
   logic [1:0]         b_si;
   logic signed [17:0] b_out;

   int n_checks = 0;
   int n_fail   = 0;

   tx_symbol_mapper #(.FIFO_DEPTH(4), .PREAMBLE_LEN(2), .FRAME_LEN(6)) u_dut_a (
      .clk(clk), .reset(reset), .clk_en(a_en), .frame_start(a_fs),
      .sym_valid(a_sv), .sym_in(a_si), .sym_ready(a_rdy), .mapper_out(a_out),
      .out_valid(a_ov), .frame_active(a_act), .underflow(a_und)
   );

   tx_symbol_mapper #(.FIFO_DEPTH(8), .PREAMBLE_LEN(2), .FRAME_LEN(3)) u_dut_b (
      .clk(clk), .reset(reset), .clk_en(b_en), .frame_start(b_fs),
      .sym_valid(b_sv), .sym_in(b_si), .sym_ready(b_rdy), .mapper_out(b_out),
      .out_valid(b_ov), .frame_active(b_act), .underflow(b_und)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_a(input logic [1:0] s);
      a_sv = 1'b1; a_si = s; tick(); a_sv = 1'b0;
   endtask

   task automatic push_b(input logic [1:0] s);
      b_sv = 1'b1; b_si = s; tick(); b_sv = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      n_checks++; if (a_out !== Z0) begin n_fail++; $display("FAIL reset_out: got %0d expected 0", a_out); end
      n_checks++; if (a_ov !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", a_ov); end
      n_checks++; if (a_und !== 1'b0) begin n_fail++; $display("FAIL reset_underflow: got %b expected 0", a_und); end
      n_checks++; if (a_act !== 1'b0) begin n_fail++; $display("FAIL reset_frame_active: got %b expected 0", a_act); end
      n_checks++; if (a_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_sym_ready: got %b expected 1", a_rdy); end
   endtask

   task automatic test_idle_output();
      a_en = 1'b1; tick(); a_en = 1'b0;
      n_checks++; if (a_ov !== 1'b1) begin n_fail++; $display("FAIL idle_out_valid: got %b expected 1", a_ov); end
      n_checks++; if (a_out !== Z0) begin n_fail++; $display("FAIL idle_out: got %0d expected 0", a_out); end
      tick();
      n_checks++; if (a_ov !== 1'b0) begin n_fail++; $display("FAIL idle_valid_pulse: got %b expected 0", a_ov); end
   endtask

   // Fill to full, then a whole frame: preamble, four mapped symbols, two underflow slots
   task automatic test_mapping();
      logic [1:0]         syms [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
      logic               exp_rdy [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      logic signed [17:0] eo[$];
      logic               er[$], eu[$], ea[$];
      for (int i = 0; i < 4; i++) begin
         push_a(syms[i]);
         n_checks++;
         if (a_rdy !== exp_rdy[i]) begin n_fail++; $display("FAIL fill_ready[%0d]: got %b expected %b", i, a_rdy, exp_rdy[i]); end
      end
      a_fs = 1'b1; tick(); a_fs = 1'b0;
      n_checks++; if (a_act !== 1'b0) begin n_fail++; $display("FAIL latch_active: got %b expected 0", a_act); end
      for (int i = 0; i < int'(NP); i++) begin
         eo.push_back((i % 2 != 0) ? N3 : P3); er.push_back(1'b0); eu.push_back(1'b0); ea.push_back(1'b1);
      end
      eo.push_back(N3); eo.push_back(N1); eo.push_back(P1); eo.push_back(P3); eo.push_back(Z0); eo.push_back(Z0);
      for (int i = 0; i < 6; i++) er.push_back(1'b1);
      eu.push_back(1'b0); eu.push_back(1'b0); eu.push_back(1'b0); eu.push_back(1'b0); eu.push_back(1'b1); eu.push_back(1'b1);
      for (int i = 0; i < 5; i++) ea.push_back(1'b1);
      ea.push_back(1'b0);
      for (int k = 0; k < eo.size(); k++) begin
         a_en = 1'b1;
         if (k == 1) a_fs = 1'b1;
         tick();
         a_en = 1'b0; a_fs = 1'b0;
         n_checks++; if (a_out !== eo[k]) begin n_fail++; $display("FAIL map_out[%0d]: got %0d expected %0d", k, a_out, eo[k]); end
         n_checks++; if (a_ov !== 1'b1) begin n_fail++; $display("FAIL map_valid[%0d]: got %b expected 1", k, a_ov); end
         n_checks++; if (a_rdy !== er[k]) begin n_fail++; $display("FAIL map_ready[%0d]: got %b expected %b", k, a_rdy, er[k]); end
         n_checks++; if (a_und !== eu[k]) begin n_fail++; $display("FAIL map_underflow[%0d]: got %b expected %b", k, a_und, eu[k]); end
         n_checks++; if (a_act !== ea[k]) begin n_fail++; $display("FAIL map_active[%0d]: got %b expected %b", k, a_act, ea[k]); end
         tick();
         n_checks++; if (a_out !== eo[k]) begin n_fail++; $display("FAIL hold_out[%0d]: got %0d expected %0d", k, a_out, eo[k]); end
         n_checks++; if (a_ov !== 1'b0) begin n_fail++; $display("FAIL hold_valid[%0d]: got %b expected 0", k, a_ov); end
         n_checks++; if (a_und !== 1'b0) begin n_fail++; $display("FAIL hold_underflow[%0d]: got %b expected 0", k, a_und); end
      end
      a_en = 1'b1; tick(); a_en = 1'b0;
      n_checks++; if (a_out !== Z0) begin n_fail++; $display("FAIL post_frame_out: got %0d expected 0", a_out); end
      n_checks++; if (a_act !== 1'b0) begin n_fail++; $display("FAIL ignored_start_active: got %b expected 0", a_act); end
   endtask

   // Reset mid-frame drops buffered symbols; a new frame then starts normally
   task automatic test_reset_mid_frame();
      logic signed [17:0] first;
      logic signed [17:0] eo[$];
      logic               eu[$];
      first = (NP != 0) ? P3 : N1;
      push_a(2'b01);
      push_a(2'b11);
      a_fs = 1'b1; tick(); a_fs = 1'b0;
      a_en = 1'b1; tick(); a_en = 1'b0;
      n_checks++; if (a_out !== first) begin n_fail++; $display("FAIL mid_first: got %0d expected %0d", a_out, first); end
      reset = 1'b1; tick(); reset = 1'b0;
      n_checks++; if (a_out !== Z0) begin n_fail++; $display("FAIL mid_reset_out: got %0d expected 0", a_out); end
      n_checks++; if (a_act !== 1'b0) begin n_fail++; $display("FAIL mid_reset_active: got %b expected 0", a_act); end
      n_checks++; if (a_rdy !== 1'b1) begin n_fail++; $display("FAIL mid_reset_ready: got %b expected 1", a_rdy); end
      n_checks++; if (a_ov !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid: got %b expected 0", a_ov); end
      push_a(2'b00);
      a_fs = 1'b1; tick(); a_fs = 1'b0;
      for (int i = 0; i < int'(NP); i++) begin
         eo.push_back((i % 2 != 0) ? N3 : P3); eu.push_back(1'b0);
      end
      eo.push_back(N3); eu.push_back(1'b0);
      for (int i = 0; i < 5; i++) begin eo.push_back(Z0); eu.push_back(1'b1); end
      for (int k = 0; k < eo.size(); k++) begin
         a_en = 1'b1; tick(); a_en = 1'b0;
         n_checks++; if (a_out !== eo[k]) begin n_fail++; $display("FAIL restart_out[%0d]: got %0d expected %0d", k, a_out, eo[k]); end
         n_checks++; if (a_und !== eu[k]) begin n_fail++; $display("FAIL restart_underflow[%0d]: got %b expected %b", k, a_und, eu[k]); end
      end
      n_checks++; if (a_act !== 1'b0) begin n_fail++; $display("FAIL restart_end_active: got %b expected 0", a_act); end
   endtask

   // FRAME_LEN=3 with 5 buffered; leftover 2 go out in the next frame alongside a same-cycle push
   task automatic test_frame_len();
      logic [1:0]         syms [5] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b11};
      logic signed [17:0] e1[$];
      logic signed [17:0] e2[$];
      for (int i = 0; i < 5; i++) push_b(syms[i]);
      for (int i = 0; i < int'(NP); i++) begin
         e1.push_back((i % 2 != 0) ? N3 : P3); e2.push_back((i % 2 != 0) ? N3 : P3);
      end
      e1.push_back(P1); e1.push_back(P3); e1.push_back(N3);
      e2.push_back(N1); e2.push_back(P1); e2.push_back(P3);
      b_fs = 1'b1; tick(); b_fs = 1'b0;
      for (int k = 0; k < e1.size(); k++) begin
         b_en = 1'b1; tick(); b_en = 1'b0;
         n_checks++; if (b_out !== e1[k]) begin n_fail++; $display("FAIL flen_out[%0d]: got %0d expected %0d", k, b_out, e1[k]); end
         n_checks++; if (b_und !== 1'b0) begin n_fail++; $display("FAIL flen_underflow[%0d]: got %b expected 0", k, b_und); end
      end
      n_checks++; if (b_act !== 1'b0) begin n_fail++; $display("FAIL flen_end_active: got %b expected 0", b_act); end
      b_en = 1'b1; tick(); b_en = 1'b0;
      n_checks++; if (b_out !== Z0) begin n_fail++; $display("FAIL flen_idle_out: got %0d expected 0", b_out); end
      b_fs = 1'b1; tick(); b_fs = 1'b0;
      for (int k = 0; k < e2.size(); k++) begin
         b_en = 1'b1;
         if (k == int'(NP)) begin b_sv = 1'b1; b_si = 2'b10; end
         tick();
         b_en = 1'b0; b_sv = 1'b0;
         n_checks++; if (b_out !== e2[k]) begin n_fail++; $display("FAIL leftover_out[%0d]: got %0d expected %0d", k, b_out, e2[k]); end
         n_checks++; if (b_und !== 1'b0) begin n_fail++; $display("FAIL leftover_underflow[%0d]: got %b expected 0", k, b_und); end
      end
      n_checks++; if (b_act !== 1'b0) begin n_fail++; $display("FAIL leftover_end_active: got %b expected 0", b_act); end
   endtask

   initial begin
      reset = 1'b1;
      a_en = 1'b0; a_fs = 1'b0; a_sv = 1'b0; a_si = 2'b00;
      b_en = 1'b0; b_fs = 1'b0; b_sv = 1'b0; b_si = 2'b00;
      test_reset();
      test_idle_output();
      test_mapping();
      test_reset_mid_frame();
      test_frame_len();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
